// File: rtl/l15_resp_pkg.sv
// Shared types for the L1.5 request responder: request/return type enums,
// access-size encoding and the byte-enable helper.
package l15_resp_pkg;

  localparam int unsigned BeatWidth = 64;
  localparam int unsigned BeWidth   = 8;

  typedef enum logic [1:0] {
    REQ_LOAD  = 2'd0,
    REQ_STORE = 2'd1,
    REQ_IFILL = 2'd2,
    REQ_RSVD  = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    RTRN_LOAD_RET  = 2'd0,
    RTRN_ST_ACK    = 2'd1,
    RTRN_IFILL_RET = 2'd2,
    RTRN_ERR       = 2'd3
  } rtrn_type_e;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2,
    SIZE_8B = 2'd3
  } size_e;

  // Lane mask for the access size, shifted to the byte offset; lanes past
  // byte 7 fall off the top of the word.
  function automatic logic [BeWidth-1:0] size_to_be(input size_e size, input logic [2:0] offset);
    logic [15:0] mask;
    unique case (size)
      SIZE_1B: mask = 16'h0001;
      SIZE_2B: mask = 16'h0003;
      SIZE_4B: mask = 16'h000F;
      default: mask = 16'h00FF;
    endcase
    mask = mask << offset;
    return mask[BeWidth-1:0];
  endfunction

endpackage

// File: rtl/l15_resp_endian_swap.sv
// Byte-lane reorder for one 64-bit beat and its byte enables.
// Big-endian operation is selected with L15_RESP_BIG_ENDIAN_EN; otherwise pass-through.
module l15_resp_endian_swap
  import l15_resp_pkg::*;
(
  input  logic [BeatWidth-1:0] i_data,
  input  logic [BeWidth-1:0]   i_be,
  output logic [BeatWidth-1:0] o_data,
  output logic [BeWidth-1:0]   o_be
);

`ifdef L15_RESP_BIG_ENDIAN_EN
  always_comb begin
    o_data = '0;
    o_be   = '0;
    for (int unsigned i = 0; i < BeWidth; i++) begin
      o_data[8*i +: 8] = i_data[8*(BeWidth-1-i) +: 8];
      o_be[i]          = i_be[BeWidth-1-i];
    end
  end
`else
  assign o_data = i_data;
  assign o_be   = i_be;
`endif

endmodule

// File: rtl/l15_req_responder.sv
// L1.5 request responder: one outstanding LOAD/STORE/IFILL request mapped onto
// a 64-bit memory port. Big-endian lanes with L15_RESP_BIG_ENDIAN_EN.
module l15_req_responder
  import l15_resp_pkg::*;
#(
  parameter int unsigned AddrWidth = 40,
  parameter int unsigned TidWidth  = 2,
  parameter int unsigned LineWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_val_i,
  output logic                 req_ack_o,
  input  logic [1:0]           req_type_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [1:0]           req_size_i,
  input  logic [TidWidth-1:0]  req_tid_i,
  input  logic [63:0]          req_data_i,
  output logic                 rtrn_val_o,
  input  logic                 rtrn_rdy_i,
  output logic [1:0]           rtrn_type_o,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic [LineWidth-1:0] rtrn_data_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [7:0]           mem_be_o,
  output logic [63:0]          mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [63:0]          mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e                r_state;
  req_type_e             r_type;
  size_e                 r_size;
  logic [AddrWidth-1:0]  r_addr;
  logic [TidWidth-1:0]   r_tid;
  logic [BeatWidth-1:0]  r_wdata;
  rtrn_type_e            r_rtype;
  logic [LineWidth-1:0]  r_rdata;
  logic                  r_mem_req;
  logic                  r_granted;
  logic                  r_rtrn_val;

  logic [AddrWidth-1:0]  w_addr_al8;
  logic [AddrWidth-1:0]  w_line_lo;
  logic [AddrWidth-1:0]  w_line_hi;
  logic [BeWidth-1:0]    w_be_raw;
  logic [BeWidth-1:0]    w_wr_be;
  logic [BeatWidth-1:0]  w_wr_data;
  logic [BeatWidth-1:0]  w_rd_data;
  logic [BeWidth-1:0]    w_rd_be_unused;

  assign w_addr_al8 = {r_addr[AddrWidth-1:3], 3'b000};
  assign w_line_lo  = {r_addr[AddrWidth-1:4], 4'h0};
  assign w_line_hi  = {r_addr[AddrWidth-1:4], 4'h8};
  assign w_be_raw   = size_to_be(r_size, r_addr[2:0]);

  l15_resp_endian_swap u_wr_swap (
    .i_data (r_wdata),
    .i_be   (w_be_raw),
    .o_data (w_wr_data),
    .o_be   (w_wr_be)
  );

  l15_resp_endian_swap u_rd_swap (
    .i_data (mem_rdata_i),
    .i_be   ('0),
    .o_data (w_rd_data),
    .o_be   (w_rd_be_unused)
  );

  // Accept is gated by reset so nothing is acknowledged while rst_ni is low.
  assign req_ack_o   = rst_ni && (r_state == S_IDLE) && req_val_i;
  assign mem_req_o   = r_mem_req;
  assign rtrn_val_o  = r_rtrn_val;
  assign rtrn_type_o = r_rtype;
  assign rtrn_tid_o  = r_tid;
  assign rtrn_data_o = r_rdata;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    unique case (r_state)
      S_RD0: mem_addr_o = (r_type == REQ_IFILL) ? w_line_lo : w_addr_al8;
      S_RD1: mem_addr_o = w_line_hi;
      S_WR: begin
        mem_addr_o  = w_addr_al8;
        mem_we_o    = 1'b1;
        mem_be_o    = w_wr_be;
        mem_wdata_o = w_wr_data;
      end
      default: ;
    endcase
  end

  // r_granted opens the rvalid window only after the current beat's grant edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_type     <= REQ_LOAD;
      r_size     <= SIZE_1B;
      r_addr     <= '0;
      r_tid      <= '0;
      r_wdata    <= '0;
      r_rtype    <= RTRN_LOAD_RET;
      r_rdata    <= '0;
      r_mem_req  <= 1'b0;
      r_granted  <= 1'b0;
      r_rtrn_val <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_val_i) begin
            r_type    <= req_type_e'(req_type_i);
            r_size    <= size_e'(req_size_i);
            r_addr    <= req_addr_i;
            r_tid     <= req_tid_i;
            r_wdata   <= req_data_i;
            r_rdata   <= '0;
            r_granted <= 1'b0;
            unique case (req_type_e'(req_type_i))
              REQ_LOAD: begin
                r_rtype   <= RTRN_LOAD_RET;
                r_mem_req <= 1'b1;
                r_state   <= S_RD0;
              end
              REQ_IFILL: begin
                r_rtype   <= RTRN_IFILL_RET;
                r_mem_req <= 1'b1;
                r_state   <= S_RD0;
              end
              REQ_STORE: begin
                r_rtype   <= RTRN_ST_ACK;
                r_mem_req <= 1'b1;
                r_state   <= S_WR;
              end
              default: begin
                r_rtype    <= RTRN_ERR;
                r_rtrn_val <= 1'b1;
                r_state    <= S_RESP;
              end
            endcase
          end
        end
        S_RD0: begin
          if (r_mem_req && mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_granted <= 1'b1;
          end else if (r_granted && mem_rvalid_i) begin
            r_rdata[0 +: BeatWidth] <= w_rd_data;
            r_granted               <= 1'b0;
            if (r_type == REQ_IFILL) begin
              r_mem_req <= 1'b1;
              r_state   <= S_RD1;
            end else begin
              r_rtrn_val <= 1'b1;
              r_state    <= S_RESP;
            end
          end
        end
        S_RD1: begin
          if (r_mem_req && mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_granted <= 1'b1;
          end else if (r_granted && mem_rvalid_i) begin
            r_rdata[BeatWidth +: BeatWidth] <= w_rd_data;
            r_granted                       <= 1'b0;
            r_rtrn_val                      <= 1'b1;
            r_state                         <= S_RESP;
          end
        end
        S_WR: begin
          if (mem_gnt_i) begin
            r_mem_req  <= 1'b0;
            r_rtrn_val <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rtrn_rdy_i) begin
            r_rtrn_val <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l15_req_responder.sv
// Directed scoreboard bench for l15_req_responder; expectations follow
// L15_RESP_BIG_ENDIAN_EN when it is defined for the build.
module tb_l15_req_responder;

  typedef struct packed {
    logic [39:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic [1:0]   typ;
    logic [1:0]   tid;
    logic [127:0] data;
  } rtrn_exp_t;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         req_val_i;
  logic         req_ack_o;
  logic [1:0]   req_type_i;
  logic [39:0]  req_addr_i;
  logic [1:0]   req_size_i;
  logic [1:0]   req_tid_i;
  logic [63:0]  req_data_i;
  logic         rtrn_val_o;
  logic         rtrn_rdy_i = 1'b0;
  logic [1:0]   rtrn_type_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;
  logic         mem_req_o;
  logic         mem_gnt_i = 1'b0;
  logic         mem_we_o;
  logic [39:0]  mem_addr_o;
  logic [7:0]   mem_be_o;
  logic [63:0]  mem_wdata_o;
  logic         mem_rvalid_i = 1'b0;
  logic [63:0]  mem_rdata_i = '0;

  int gnt_wait = 0;
  int rdy_wait = 0;
  logic        ov_en   = 1'b0;
  logic [39:0] ov_addr = '0;
  logic [63:0] ov_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_exp_t  exp_mem[$];
  rtrn_exp_t exp_rtrn[$];

  logic       p_mreq, p_mgnt, p_rval, p_rrdy;
  logic [112:0] p_mem;
  logic [131:0] p_rtrn;

  l15_req_responder #(.AddrWidth(40), .TidWidth(2), .LineWidth(128)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_val_i(req_val_i), .req_ack_o(req_ack_o), .req_type_i(req_type_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_tid_i(req_tid_i),
    .req_data_i(req_data_i),
    .rtrn_val_o(rtrn_val_o), .rtrn_rdy_i(rtrn_rdy_i), .rtrn_type_o(rtrn_type_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [39:0] a);
    if (ov_en && a == ov_addr) return ov_data;
    return {a[31:0] ^ 32'hC3A5_5A3C, ~a[31:0]};
  endfunction

  function automatic logic [63:0] sw(input logic [63:0] d);
`ifdef L15_RESP_BIG_ENDIAN_EN
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  function automatic logic [7:0] be_calc(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] b;
    logic [7:0] m;
    b = '0;
    for (int i = 0; i < (1 << size); i++)
      if (int'(off) + i < 8) b[int'(off) + i] = 1'b1;
`ifdef L15_RESP_BIG_ENDIAN_EN
    for (int i = 0; i < 8; i++) m[i] = b[7-i];
`else
    m = b;
`endif
    return m;
  endfunction

  // Memory and return-channel responder: grant after gnt_wait stall cycles,
  // read data the cycle after the grant, ready after rdy_wait cycles.
  logic        rd_pend = 1'b0;
  logic [39:0] pend_addr = '0;
  logic        g_busy = 1'b0, r_busy = 1'b0;
  int          g_cnt = 0, r_cnt = 0;

  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (rd_pend) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(pend_addr);
      rd_pend      = 1'b0;
    end
    mem_gnt_i = 1'b0;
    if (!rst_ni) g_busy = 1'b0;
    else if (mem_req_o) begin
      if (!g_busy) begin g_busy = 1'b1; g_cnt = gnt_wait; end
      if (g_cnt == 0) begin
        mem_gnt_i = 1'b1;
        g_busy    = 1'b0;
        if (!mem_we_o) begin rd_pend = 1'b1; pend_addr = mem_addr_o; end
      end else g_cnt--;
    end
    rtrn_rdy_i = 1'b0;
    if (!rst_ni) r_busy = 1'b0;
    else if (rtrn_val_o) begin
      if (!r_busy) begin r_busy = 1'b1; r_cnt = rdy_wait; end
      if (r_cnt == 0) begin rtrn_rdy_i = 1'b1; r_busy = 1'b0; end
      else r_cnt--;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to the sampling point of the next cycle and score DUT activity.
  task automatic tick();
    mem_exp_t  em;
    rtrn_exp_t er;
    @(negedge clk);
    #2;
    if (mem_req_o && mem_gnt_i) begin
      if (exp_mem.size() == 0) check("mem_unexpected", mem_req_o, 0);
      else begin
        em = exp_mem.pop_front();
        check("mem_beat", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, em);
      end
    end
    if (p_mreq && !p_mgnt)
      check("mem_hold", {mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, {1'b1, p_mem});
    if (rtrn_val_o && rtrn_rdy_i) begin
      if (exp_rtrn.size() == 0) check("rtrn_unexpected", rtrn_val_o, 0);
      else begin
        er = exp_rtrn.pop_front();
        check("rtrn", {rtrn_type_o, rtrn_tid_o, rtrn_data_o}, er);
      end
    end
    if (p_rval && !p_rrdy)
      check("rtrn_hold", {rtrn_val_o, rtrn_type_o, rtrn_tid_o, rtrn_data_o}, {1'b1, p_rtrn});
    if (req_val_i && (mem_req_o || rtrn_val_o)) check("ack_busy", req_ack_o, 0);
    p_mreq = mem_req_o;
    p_mgnt = mem_gnt_i;
    p_mem  = {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o};
    p_rval = rtrn_val_o;
    p_rrdy = rtrn_rdy_i;
    p_rtrn = {rtrn_type_o, rtrn_tid_o, rtrn_data_o};
  endtask

  task automatic run(input logic [1:0] typ, input logic [39:0] addr, input logic [1:0] size,
                     input logic [1:0] tid, input logic [63:0] data, input int exp_lat,
                     input int gw, input int rw);
    logic [39:0] al8, base;
    int lat;
    bit seen, done;
    tick();
    gnt_wait = gw;
    rdy_wait = rw;
    al8  = {addr[39:3], 3'b000};
    base = {addr[39:4], 4'h0};
    case (typ)
      2'd0: begin
        exp_mem.push_back('{addr: al8, we: 1'b0, be: 8'h00, wdata: 64'h0});
        exp_rtrn.push_back('{typ: 2'd0, tid: tid, data: {64'h0, sw(mem_word(al8))}});
      end
      2'd1: begin
        exp_mem.push_back('{addr: al8, we: 1'b1, be: be_calc(size, addr[2:0]), wdata: sw(data)});
        exp_rtrn.push_back('{typ: 2'd1, tid: tid, data: 128'h0});
      end
      2'd2: begin
        exp_mem.push_back('{addr: base, we: 1'b0, be: 8'h00, wdata: 64'h0});
        exp_mem.push_back('{addr: base + 40'd8, we: 1'b0, be: 8'h00, wdata: 64'h0});
        exp_rtrn.push_back('{typ: 2'd2, tid: tid,
                             data: {sw(mem_word(base + 40'd8)), sw(mem_word(base))}});
      end
      default: exp_rtrn.push_back('{typ: 2'd3, tid: tid, data: 128'h0});
    endcase
    req_type_i = typ; req_addr_i = addr; req_size_i = size;
    req_tid_i  = tid; req_data_i = data; req_val_i  = 1'b1;
    #1;
    check("ack", req_ack_o, 1);
    lat = 0; seen = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      lat++;
      if (rtrn_val_o && !seen) begin
        seen = 1;
        if (exp_lat >= 0) check("latency", lat, exp_lat);
      end
      if (rtrn_val_o && rtrn_rdy_i) begin
        done = 1;
        req_val_i = 1'b0;
      end
    end
    req_val_i = 1'b0;
    check("done", done, 1);
    check("sb_empty", exp_mem.size() + exp_rtrn.size(), 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_val_i = 1'b1; req_type_i = 2'd0; req_addr_i = 40'hFF_FFFF_FFFF;
    req_size_i = 2'd3; req_tid_i = 2'd3; req_data_i = '1;
    p_mreq = 0; p_mgnt = 0; p_rval = 0; p_rrdy = 0; p_mem = '0; p_rtrn = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {req_ack_o, rtrn_val_o, rtrn_type_o, rtrn_tid_o, rtrn_data_o,
                            mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, '0);
    req_val_i = 1'b0;
    rst_ni = 1'b1;

    ov_en = 1'b1; ov_addr = 40'h80_0000_0008; ov_data = 64'h0011_2233_4455_6677;
    run(2'd0, 40'h80_0000_0008, 2'd3, 2'd2, 64'h0, 3, 0, 0);
    ov_en = 1'b0;
    run(2'd2, 40'h80_0000_0018, 2'd3, 2'd1, 64'h0, 5, 0, 0);
    run(2'd1, 40'h80_0000_0026, 2'd1, 2'd0, 64'hABCD_0000_0000_0000, 2, 0, 0);
    run(2'd1, 40'h00_1234_5673, 2'd0, 2'd3, 64'h0000_0000_5A00_0000, 2, 0, 0);
    run(2'd1, 40'h00_0000_0F04, 2'd2, 2'd1, 64'hDEAD_BEEF_0000_0000, 2, 0, 0);
    run(2'd1, 40'h00_0000_0F07, 2'd3, 2'd2, 64'h0123_4567_89AB_CDEF, 2, 0, 0);
    run(2'd0, 40'h12_3456_7895, 2'd2, 2'd3, 64'h0, -1, 4, 0);
    run(2'd0, 40'h00_0000_0040, 2'd3, 2'd0, 64'h0, 3, 0, 3);
    run(2'd3, 40'h80_0000_0000, 2'd0, 2'd1, 64'hFFFF, 1, 0, 0);
    run(2'd2, 40'hAB_CDEF_012C, 2'd3, 2'd2, 64'h0, -1, 2, 2);

    // IFILL aborted by reset right after its second-beat grant; the read data
    // then arrives with the block already idle.
    tick();
    gnt_wait = 0; rdy_wait = 0;
    exp_mem.push_back('{addr: 40'h00_0000_1100, we: 1'b0, be: 8'h00, wdata: 64'h0});
    exp_mem.push_back('{addr: 40'h00_0000_1108, we: 1'b0, be: 8'h00, wdata: 64'h0});
    req_type_i = 2'd2; req_addr_i = 40'h00_0000_110C; req_size_i = 2'd3;
    req_tid_i = 2'd1; req_val_i = 1'b1;
    #1;
    check("abort_ack", req_ack_o, 1);
    tick();
    req_val_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    check("abort_reset_outputs", {req_ack_o, rtrn_val_o, rtrn_type_o, rtrn_tid_o, rtrn_data_o,
                                  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, '0);
    rst_ni = 1'b1;
    tick();
    check("late_rvalid_ignored", {rtrn_val_o, mem_req_o, rtrn_data_o}, '0);
    tick();
    check("no_return_after_abort", {rtrn_val_o, mem_req_o}, '0);
    check("abort_sb_empty", exp_mem.size() + exp_rtrn.size(), 0);

    run(2'd0, 40'h80_0000_0010, 2'd3, 2'd3, 64'h0, 3, 0, 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
